piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Parametrised parallel-in/serial-out shifter with valid/ready load handshake.
//  Accepts a WIDTH-bit word, then emits it one bit per shift_en strobe, MSB- or LSB-first.
//  Supports gapless back-to-back frames and marks the first bit of each frame.
//  Sits between a parallel producer (FIFO/register bank) and a serial line driver.
// PARAMETERS
//  WIDTH      8  word width in bits; legal range 2..64
//  LSB_FIRST  0  0 = shift MSB first, 1 = shift LSB first
// PORTS
//  clk          in   1      single clock; all state updates on its rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  in_valid     in   1      producer has a word on in_data
//  in_ready     out  1      block can accept a word this cycle
//  in_data      in   WIDTH  parallel word; sampled only on accept
//  shift_en     in   1      bit-rate strobe; tie to 1 for one bit per clock
//  serial_out   out  1      current serial bit; 0 when idle
//  serial_valid out  1      serial_out carries a frame bit
//  frame_start  out  1      high while bit 0 of a frame is on serial_out
//  busy         out  1      frame in progress (same as serial_valid)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, shreg=0, cnt=0.
//    Outputs: serial_out=0, serial_valid=0, frame_start=0, busy=0, in_ready=1.
//  - FSM has two states, IDLE and SHIFT.
//  - Accept = in_valid && in_ready at a rising edge. On accept: shreg<=in_data, cnt<=0, state<=SHIFT.
//  - Latency: the first bit appears on serial_out in the cycle after accept.
//  - serial_out = shreg[WIDTH-1] (MSB-first) or shreg[0] (LSB-first) in SHIFT; forced to 0 in IDLE.
//  - In SHIFT, each bit holds until an edge with shift_en=1. On that edge:
//    - cnt<WIDTH-1: shreg shifts one place toward the output end, zero-filled; cnt++.
//    - cnt==WIDTH-1 (last bit): if accept in the same edge, reload and stay in SHIFT (no gap).
//      Otherwise state<=IDLE.
//  - in_ready = (state==IDLE) || (state==SHIFT && cnt==WIDTH-1 && shift_en); combinational.
//  - in_valid has no combinational path to in_ready.
//  - Words are never accepted in the middle of a frame. in_data is ignored while in_ready=0.
//  - shift_en is ignored in IDLE. An accept with shift_en=0 still loads.
//  - serial_valid = busy = (state==SHIFT); frame_start = serial_valid && cnt==0.
//  - cnt width = $clog2(WIDTH); wraps only via reload or a return to IDLE, never by overflow.
//  - Async reset mid-frame aborts the frame immediately; the partial word is discarded.
//    There is no resume after release; the first accept after release starts a fresh frame.
//  - in_valid held high continuously: frames run back-to-back with exactly WIDTH shift_en strobes each.
// STRUCTURE
//  - Shared package shift_reg_pkg holds:
//    - state encodings ST_IDLE=1'b0 and ST_SHIFT=1'b1
//    - a bit-order macro/localparam pair (MSB_FIRST=0, LSB_FIRST=1), shared with the future SIPO successor
//  - One natural sub-module: bit_counter (mod-WIDTH counter with enable, clear, and terminal-count output).
//  - The shift register and FSM stay inline.
// TESTING
//  1. Reset, WIDTH=8, MSB-first, shift_en=1, load 8'hAA
//     -> serial_out 1,0,1,0,1,0,1,0 over 8 cycles starting the cycle after accept; frame_start only on the first.
//  2. LSB_FIRST=1, load 8'hCC
//     -> serial_out 0,0,1,1,0,0,1,1; then serial_valid=0 and in_ready=1.
//  3. in_valid held high with 8'hF0 then 8'h0F, shift_en=1
//     -> 16 consecutive valid bits 11110000_00001111, no idle cycle between frames.
//     -> in_ready high only on the last-bit cycle of each frame.
//  4. shift_en high every 3rd cycle, load 8'hA5
//     -> each bit held 3 cycles; frame lasts 24 cycles; in_data changes mid-frame are ignored.
//  5. rst_n low after 3 bits of 8'hFF
//     -> serial_out=0, serial_valid=0, busy=0 asynchronously.
//     -> after release, load 8'h81 -> bits 1,0,0,0,0,0,0,1.
//  6. WIDTH=2, LSB_FIRST=0, load 2'b10 with shift_en=0 for 4 cycles
//     -> serial_out stays 1 with serial_valid=1 for those cycles, then 1,0 once shift_en=1.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift-register family (PISO now, SIPO later):
// FSM encodings, bit-order selectors and counter sizing.
package shift_reg_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam bit ORDER_MSB_FIRST = 1'b0;
  localparam bit ORDER_LSB_FIRST = 1'b1;

  // Bit index counter width; never below 1 so a port can always be declared.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Mod-WIDTH bit index counter: clear wins over enable, tc flags the last bit.
module bit_counter
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  output logic [cnt_w(WIDTH)-1:0] cnt,
  output logic                    tc
);

  localparam int CW = cnt_w(WIDTH);

  assign tc = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= tc ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: valid/ready word load, one bit per shift_en
// strobe, gapless reload on the last bit of a frame.
module piso_serializer
  import shift_reg_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = ORDER_MSB_FIRST
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW     = cnt_w(WIDTH);
  localparam bit LSB_OUT = (LSB_FIRST == ORDER_LSB_FIRST);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             last, step, accept;

  assign step     = (state == ST_SHIFT) && shift_en;
  // Ready only depends on state/count/strobe, never on in_valid.
  assign in_ready = (state == ST_IDLE) || (step && last);
  assign accept   = in_valid && in_ready;

  bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (step),
    .cnt   (cnt),
    .tc    (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
      ST_SHIFT: if (step && last && !accept) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Shift toward the output end with zero fill; a reload overrides the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      shreg <= '0;
    else if (accept) shreg <= in_data;
    else if (step) begin
      if (LSB_OUT) shreg <= {1'b0, shreg[WIDTH-1:1]};
      else         shreg <= {shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign serial_valid = (state == ST_SHIFT);
  assign busy         = serial_valid;
  assign serial_out   = serial_valid && (LSB_OUT ? shreg[0] : shreg[WIDTH-1]);
  assign frame_start  = serial_valid && (cnt == '0);

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: three serializer configurations share clock, reset and
// strobe; each accepted word pushes its expected bit sequence for the monitor.
module tb_piso_serializer;

  typedef struct {
    logic b;
    logic first;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] iv = '0;
  logic [7:0] in_data = '0;
  logic       se_lvl = 1'b1;
  logic       se_div3 = 1'b0;
  int         cyc = 0;
  logic       shift_en;
  logic [2:0] rdy, so, sv, fs, bz;

  int total = 0;
  int bad = 0;
  exp_t q[3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign shift_en = se_div3 ? (cyc % 3 == 0) : se_lvl;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_m8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]), .in_data(in_data),
    .shift_en(shift_en), .serial_out(so[0]), .serial_valid(sv[0]), .frame_start(fs[0]), .busy(bz[0]));

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_l8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]), .in_data(in_data),
    .shift_en(shift_en), .serial_out(so[1]), .serial_valid(sv[1]), .frame_start(fs[1]), .busy(bz[1]));

  piso_serializer #(.WIDTH(2), .LSB_FIRST(1'b0)) u_m2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy[2]), .in_data(in_data[1:0]),
    .shift_en(shift_en), .serial_out(so[2]), .serial_valid(sv[2]), .frame_start(fs[2]), .busy(bz[2]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic string tg(input string n, input int ch);
    return $sformatf("%s[%0d]", n, ch);
  endfunction

  // Peek the expected bit, pop on a strobe, then push a new frame on accept.
  task automatic mon(input int ch, input int w, input bit lsb);
    exp_t e;
    logic act;
    act = (q[ch].size() != 0);
    chk(tg("serial_valid", ch), sv[ch], act);
    chk(tg("busy", ch), bz[ch], act);
    chk(tg("in_ready", ch), rdy[ch], !act || (q[ch].size() == 1 && shift_en));
    if (act) begin
      e = q[ch][0];
      chk(tg("serial_out", ch), so[ch], e.b);
      chk(tg("frame_start", ch), fs[ch], e.first);
      if (shift_en) void'(q[ch].pop_front());
    end else begin
      chk(tg("idle_out", ch), so[ch], 1'b0);
      chk(tg("idle_fs", ch), fs[ch], 1'b0);
    end
    if (iv[ch] && rdy[ch] && rst_n) begin
      for (int i = 0; i < w; i++) begin
        e.b     = lsb ? in_data[i] : in_data[w-1-i];
        e.first = (i == 0);
        q[ch].push_back(e);
      end
    end
  endtask

  always @(negedge clk) mon(0, 8, 1'b0);
  always @(negedge clk) mon(1, 8, 1'b1);
  always @(negedge clk) mon(2, 2, 1'b0);

  task automatic send(input int ch, input logic [7:0] d);
    logic got;
    got = 1'b0;
    in_data = d;
    iv[ch]  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rdy[ch]) begin
        got = 1'b1;
        break;
      end
    end
    chk(tg("accept_timeout", ch), got, 1'b1);
    @(posedge clk);
    #1;
    iv[ch] = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 && sv == 3'b000) begin
        done = 1'b1;
        break;
      end
    end
    chk("idle_timeout", done, 1'b1);
  endtask

  initial begin
    #1;
    chk("rst_valid", {sv, bz, fs, so}, 12'h000);
    chk("rst_ready", rdy, 3'b111);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // MSB-first 8'hAA, then LSB-first 8'hCC
    send(0, 8'hAA);
    wait_idle();
    send(1, 8'hCC);
    wait_idle();

    // Back-to-back frames with in_valid held high
    send(0, 8'hF0);
    send(0, 8'h0F);
    wait_idle();

    // Strobe every third cycle; in_data churns mid-frame with in_valid low
    se_div3 = 1'b1;
    send(0, 8'hA5);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      in_data = 8'($urandom);
    end
    wait_idle();
    send(1, 8'h3C);
    wait_idle();
    se_div3 = 1'b0;

    // Asynchronous reset in the middle of an 8'hFF frame
    send(0, 8'hFF);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out", so[0], 1'b0);
    chk("abort_valid", sv[0], 1'b0);
    chk("abort_busy", bz[0], 1'b0);
    chk("abort_ready", rdy[0], 1'b1);
    for (int c = 0; c < 3; c++) q[c].delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(0, 8'h81);
    wait_idle();

    // WIDTH=2 held by shift_en=0, then released
    se_lvl = 1'b0;
    send(2, 8'h02);
    repeat (4) @(posedge clk);
    #1;
    chk("hold_out", so[2], 1'b1);
    se_lvl = 1'b1;
    wait_idle();

    // A few random frames across all lanes
    for (int k = 0; k < 4; k++) begin
      send(k % 3, 8'($urandom));
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
